miner_host_ctrl: RTL and testbench

- Synthesizable host-side sequencer for the single-core Bitcoin miner.
- Issues network packets to the core's packet input to do the following:
  - program the barrier mask;
  - load midstate and work words;
  - issue LDWORK, LDNONCE and DONE commands;
  - restart the core PC.
- Watches the core's barrier_o to decide the next nonce or declare a find.
- Sits between a host register interface and core_flattened's net_packet input.

---
 rtl/miner_host_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_miner_host_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_host_ctrl.sv
// Host-side packet sequencer for the single-core miner: loads midstate/work, steps
// nonces through LDNONCE groups and reports find, exhaustion or error from barrier_i.
module miner_host_ctrl #(
  parameter logic [9:0]  NET_ID         = 10'd1,
  parameter logic [2:0]  OP_NULL        = 3'd0,
  parameter logic [2:0]  OP_INSTR       = 3'd1,
  parameter logic [2:0]  OP_REG         = 3'd2,
  parameter logic [2:0]  OP_PC          = 3'd3,
  parameter logic [2:0]  OP_BAR         = 3'd4,
  parameter int          GUARD_CYCLES   = 4,
  parameter int          SETTLE_CYCLES  = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [255:0] midstate_i,
  input  logic [95:0]  work_i,
  input  logic [31:0]  nonce_start_i,
  input  logic [2:0]   barrier_i,
  input  logic         exception_i,
  output logic [9:0]   net_id_o,
  output logic [2:0]   net_op_o,
  output logic [31:0]  net_data_o,
  output logic [9:0]   net_addr_o,
  output logic         busy_o,
  output logic         found_o,
  output logic         exhausted_o,
  output logic         error_o,
  output logic [31:0]  nonce_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOADWORK, ST_WAIT, ST_SETTLE, ST_LDNONCE, ST_FINISH, ST_DONE, ST_ERROR
  } state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [9:0]  addr;
    logic [31:0] data;
  } pkt_t;

  localparam pkt_t       HOLD_PKT    = '{op: OP_NULL, addr: 10'd24, data: 32'hFFFF_FFFE};
  localparam logic [7:0] GUARD_LAST  = 8'(GUARD_CYCLES);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  function automatic pkt_t mk_pkt(input logic [2:0] op, input logic [9:0] addr,
                                  input logic [31:0] data);
    pkt_t p;
    p.op   = op;
    p.addr = addr;
    p.data = data;
    return p;
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     guard_q, guard_d;
  logic [7:0]     settle_q, settle_d;
  logic [31:0]    tmo_q, tmo_d;
  logic [255:0]   midstate_q, midstate_d;
  logic [95:0]    work_q, work_d;
  logic [31:0]    nonce_start_q, nonce_start_d;
  logic [31:0]    nonce_q, nonce_d;
  logic           phase_nonce_q, phase_nonce_d;
  logic           to_finish_q, to_finish_d;
  logic           exc_pend_q, exc_pend_d;
  logic           busy_q, busy_d;
  logic           found_q, found_d;
  logic           exhausted_q, exhausted_d;
  logic           error_q, error_d;
  pkt_t           pkt_q, pkt_d;

  logic [7:0]     mid_base;
  logic [6:0]     work_base;
  logic           guard_done;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    guard_d       = guard_q;
    settle_d      = settle_q;
    tmo_d         = tmo_q;
    midstate_d    = midstate_q;
    work_d        = work_q;
    nonce_start_d = nonce_start_q;
    nonce_d       = nonce_q;
    phase_nonce_d = phase_nonce_q;
    to_finish_d   = to_finish_q;
    exc_pend_d    = exc_pend_q;
    busy_d        = busy_q;
    found_d       = found_q;
    exhausted_d   = exhausted_q;
    error_d       = error_q;
    pkt_d         = HOLD_PKT;
    mid_base      = {idx_q[2:0] - 3'd1, 5'd0};
    work_base     = {idx_q[1:0] - 2'd1, 5'd0};
    guard_done    = (guard_q >= GUARD_LAST);

    // An exception raised while packets are in flight is acted on once WAIT is reached.
    if (exception_i && (state_q inside {ST_LOADWORK, ST_SETTLE, ST_LDNONCE}))
      exc_pend_d = 1'b1;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          midstate_d    = midstate_i;
          work_d        = work_i;
          nonce_start_d = nonce_start_i;
          found_d       = 1'b0;
          exhausted_d   = 1'b0;
          error_d       = 1'b0;
          exc_pend_d    = 1'b0;
          busy_d        = 1'b1;
          idx_d         = 4'd0;
          state_d       = ST_LOADWORK;
        end
      end

      ST_LOADWORK: begin
        if (idx_q == 4'd0)       pkt_d = mk_pkt(OP_BAR, 10'd24, 32'd7);
        else if (idx_q <= 4'd8)  pkt_d = mk_pkt(OP_REG, {6'd0, idx_q}, midstate_q[mid_base +: 32]);
        else if (idx_q <= 4'd11) pkt_d = mk_pkt(OP_REG, {6'd0, idx_q}, work_q[work_base +: 32]);
        else if (idx_q == 4'd12) pkt_d = mk_pkt(OP_REG, 10'd20, 32'd1);
        else if (idx_q == 4'd13) pkt_d = mk_pkt(OP_PC, 10'd0, 32'd2);
        if (idx_q == 4'd14) begin
          phase_nonce_d = 1'b0;
          guard_d       = 8'd0;
          tmo_d         = 32'd0;
          idx_d         = 4'd0;
          state_d       = ST_WAIT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      ST_WAIT: begin
        tmo_d = tmo_q + 32'd1;
        if (!guard_done) guard_d = guard_q + 8'd1;
        settle_d = 8'd0;
        if (exception_i || exc_pend_q) begin
          exc_pend_d = 1'b0;
          error_d    = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_ERROR;
        end else if (guard_done && barrier_i == 3'b001) begin
          found_d     = 1'b1;
          to_finish_d = 1'b1;
          state_d     = ST_SETTLE;
        end else if (guard_done && barrier_i == 3'b000) begin
          if (!phase_nonce_q) begin
            nonce_d     = nonce_start_q;
            to_finish_d = 1'b0;
            state_d     = ST_SETTLE;
          end else if (nonce_q == 32'hFFFF_FFFF || nonce_q + 32'd1 == nonce_start_q) begin
            exhausted_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_DONE;
          end else begin
            nonce_d     = nonce_q + 32'd1;
            to_finish_d = 1'b0;
            state_d     = ST_SETTLE;
          end
        end else if (tmo_q == TIMEOUT_CYCLES) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_ERROR;
        end
      end

      ST_SETTLE: begin
        if (settle_q >= SETTLE_LAST) begin
          idx_d   = 4'd0;
          state_d = to_finish_q ? ST_FINISH : ST_LDNONCE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end

      ST_LDNONCE: begin
        case (idx_q)
          4'd0:    pkt_d = mk_pkt(OP_REG, 10'd1, nonce_q);
          4'd1:    pkt_d = mk_pkt(OP_REG, 10'd20, 32'd2);
          4'd2:    pkt_d = mk_pkt(OP_PC, 10'd0, 32'd2);
          default: pkt_d = HOLD_PKT;
        endcase
        if (idx_q == 4'd3) begin
          phase_nonce_d = 1'b1;
          guard_d       = 8'd0;
          tmo_d         = 32'd0;
          idx_d         = 4'd0;
          state_d       = ST_WAIT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      ST_FINISH: begin
        case (idx_q)
          4'd0:    pkt_d = mk_pkt(OP_REG, 10'd20, 32'd3);
          4'd1:    pkt_d = mk_pkt(OP_PC, 10'd0, 32'd2);
          default: pkt_d = HOLD_PKT;
        endcase
        if (idx_q == 4'd2) begin
          busy_d  = 1'b0;
          idx_d   = 4'd0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Instruction memory is never written from this sequencer.
    if (pkt_d.op == OP_INSTR) pkt_d = HOLD_PKT;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= 4'd0;
      guard_q       <= 8'd0;
      settle_q      <= 8'd0;
      tmo_q         <= 32'd0;
      midstate_q    <= '0;
      work_q        <= '0;
      nonce_start_q <= 32'd0;
      nonce_q       <= 32'd0;
      phase_nonce_q <= 1'b0;
      to_finish_q   <= 1'b0;
      exc_pend_q    <= 1'b0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      error_q       <= 1'b0;
      pkt_q         <= HOLD_PKT;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      guard_q       <= guard_d;
      settle_q      <= settle_d;
      tmo_q         <= tmo_d;
      midstate_q    <= midstate_d;
      work_q        <= work_d;
      nonce_start_q <= nonce_start_d;
      nonce_q       <= nonce_d;
      phase_nonce_q <= phase_nonce_d;
      to_finish_q   <= to_finish_d;
      exc_pend_q    <= exc_pend_d;
      busy_q        <= busy_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
      error_q       <= error_d;
      pkt_q         <= pkt_d;
    end
  end

  assign net_id_o    = NET_ID;
  assign net_op_o    = pkt_q.op;
  assign net_addr_o  = pkt_q.addr;
  assign net_data_o  = pkt_q.data;
  assign busy_o      = busy_q;
  assign found_o     = found_q;
  assign exhausted_o = exhausted_q;
  assign error_o     = error_q;
  assign nonce_o     = nonce_q;

endmodule

// File: tb/tb_miner_host_ctrl.sv
// Self-checking bench for miner_host_ctrl: a core model answers each group's PC write
// with a barrier value, and a job-level reference model predicts the packet stream.
module tb_miner_host_ctrl;

  localparam int          GUARD  = 4;
  localparam int          SETTLE = 2;
  localparam logic [31:0] TMO    = 32'd100;
  localparam logic [2:0]  OP_BAR = 3'd4;
  localparam logic [2:0]  OP_REG = 3'd2;
  localparam logic [2:0]  OP_PC  = 3'd3;
  localparam logic [44:0] HOLD   = {3'd0, 10'd24, 32'hFFFF_FFFE};

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [255:0] midstate_i;
  logic [95:0]  work_i;
  logic [31:0]  nonce_start_i;
  logic [2:0]   barrier_i;
  logic         exception_i;
  logic [9:0]   net_id_o;
  logic [2:0]   net_op_o;
  logic [31:0]  net_data_o;
  logic [9:0]   net_addr_o;
  logic         busy_o, found_o, exhausted_o, error_o;
  logic [31:0]  nonce_o;

  always #5 clk = ~clk;

  miner_host_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .midstate_i(midstate_i), .work_i(work_i),
    .nonce_start_i(nonce_start_i), .barrier_i(barrier_i), .exception_i(exception_i),
    .net_id_o(net_id_o), .net_op_o(net_op_o), .net_data_o(net_data_o), .net_addr_o(net_addr_o),
    .busy_o(busy_o), .found_o(found_o), .exhausted_o(exhausted_o), .error_o(error_o),
    .nonce_o(nonce_o)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [44:0] got_q[$];
  logic [44:0] raw_q[$];
  logic [44:0] exp_q[$];
  logic [2:0]  resp_q[$];
  logic [2:0]  resp_list[$];
  logic [2:0]  idle_bar;
  logic [31:0] last_nonce;
  logic        m_found, m_exh, m_err;
  logic [31:0] m_nonce;

  function automatic logic [44:0] mk(input logic [2:0] op, input int addr, input logic [31:0] data);
    return {op, 10'(addr), data};
  endfunction

  function automatic logic [44:0] cur_pkt();
    return {net_op_o, net_addr_o, net_data_o};
  endfunction

  task automatic randomize_vectors();
    for (int k = 0; k < 8; k++) midstate_i[32*k +: 32] = $urandom;
    for (int k = 0; k < 3; k++) work_i[32*k +: 32] = $urandom;
  endtask

  // Job-level model: what packets a host must send and how the job ends.
  task automatic model_job(input logic [31:0] ns);
    logic [31:0] n;
    bit          first;
    bit          over;
    exp_q.delete();
    exp_q.push_back(mk(OP_BAR, 24, 32'd7));
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(OP_REG, k + 1, midstate_i[32*k +: 32]));
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(OP_REG, k + 9, work_i[32*k +: 32]));
    exp_q.push_back(mk(OP_REG, 20, 32'd1));
    exp_q.push_back(mk(OP_PC, 0, 32'd2));
    m_found = 1'b0; m_exh = 1'b0; m_err = 1'b0;
    n = last_nonce; first = 1'b1; over = 1'b0;
    foreach (resp_list[i]) begin
      if (!over && resp_list[i] == 3'b001) begin
        m_found = 1'b1; over = 1'b1;
        exp_q.push_back(mk(OP_REG, 20, 32'd3));
        exp_q.push_back(mk(OP_PC, 0, 32'd2));
      end else if (!over && resp_list[i] == 3'b000) begin
        if (first) begin
          n = ns; first = 1'b0;
        end else if (n == 32'hFFFF_FFFF || n + 32'd1 == ns) begin
          m_exh = 1'b1; over = 1'b1;
        end else begin
          n = n + 32'd1;
        end
        if (!over) begin
          exp_q.push_back(mk(OP_REG, 1, n));
          exp_q.push_back(mk(OP_REG, 20, 32'd2));
          exp_q.push_back(mk(OP_PC, 0, 32'd2));
        end
      end
    end
    if (!over) m_err = 1'b1;
    m_nonce = n;
  endtask

  // Starts a job and plays the core: each PC write is answered from resp_q.
  task automatic run_job(input logic [31:0] ns, input int exc_at, input int budget, output int cycles);
    logic [44:0] p;
    got_q.delete(); raw_q.delete();
    resp_q = resp_list;
    barrier_i = idle_bar;
    nonce_start_i = ns;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    nonce_start_i = $urandom;
    randomize_vectors();
    cycles = 0;
    forever begin
      p = cur_pkt();
      raw_q.push_back(p);
      exception_i = (cycles == exc_at);
      if (p != HOLD) begin
        got_q.push_back(p);
        if (p[44:42] == OP_PC && resp_q.size() != 0) barrier_i = resp_q.pop_front();
        else if (p[44:42] != OP_PC) barrier_i = idle_bar;
      end
      if (!busy_o || cycles >= budget) break;
      @(negedge clk);
      cycles++;
    end
    exception_i = 1'b0;
    n_checks++;
    if (cycles >= budget) begin
      n_fail++;
      $display("FAIL job_budget: still busy after %0d cycles, required end within %0d", cycles, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_i = 1'b0; exception_i = 1'b0; barrier_i = 3'b010;
    midstate_i = '0; work_i = '0; nonce_start_i = '0;
    #1;
    n_checks++;
    if ({net_id_o, net_op_o, net_addr_o, net_data_o} !== {10'd1, HOLD}) begin
      n_fail++;
      $display("FAIL reset_packet: got %h, required %h", {net_id_o, net_op_o, net_addr_o, net_data_o}, {10'd1, HOLD});
    end
    n_checks++;
    if ({busy_o, found_o, exhausted_o, error_o, nonce_o} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_status: got %h, required 0", {busy_o, found_o, exhausted_o, error_o, nonce_o});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_nonce = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_loadwork();
    int npk, cyc, extra;
    randomize_vectors();
    barrier_i = 3'b010;
    nonce_start_i = $urandom;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    npk = 0; cyc = 0;
    while (npk < 5 && cyc < 40) begin
      if (cur_pkt() != HOLD) npk++;
      if (npk < 5) begin @(negedge clk); cyc++; end
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (cur_pkt() !== HOLD || busy_o !== 1'b0 || npk != 5) begin
      n_fail++;
      $display("FAIL reset_mid_job: pkt %h busy %b after %0d pkts, required %h busy 0 after 5", cur_pkt(), busy_o, npk, HOLD);
    end
    @(negedge clk);
    reset = 1'b0;
    last_nonce = 32'd0;
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (cur_pkt() != HOLD || busy_o) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL reset_no_more_packets: %0d active cycles after reset, required 0", extra);
    end
  endtask

  task automatic test_loadwork();
    int cycles;
    randomize_vectors();
    resp_list = '{3'b000, 3'b000, 3'b000, 3'b001};
    idle_bar = 3'b010;
    model_job(32'd0);
    run_job(32'd0, -1, 300, cycles);
    n_checks++;
    if (raw_q.size() < 16 || raw_q[0] !== HOLD) begin
      n_fail++;
      $display("FAIL loadwork_lead: %0d cycles captured, first %h, required hold first", raw_q.size(), raw_q[0]);
    end
    for (int i = 0; i < 15 && i + 1 < raw_q.size(); i++) begin
      n_checks++;
      if (raw_q[i+1] !== ((i < 14) ? exp_q[i] : HOLD)) begin
        n_fail++;
        $display("FAIL loadwork_pkt%0d: got %h, required %h", i, raw_q[i+1], (i < 14) ? exp_q[i] : HOLD);
      end
    end
    last_nonce = m_nonce;
  endtask

  task automatic test_find_sequence();
    int cycles;
    randomize_vectors();
    resp_list = '{3'b000, 3'b000, 3'b000, 3'b001};
    idle_bar = 3'b011;
    model_job(32'd0);
    run_job(32'd0, -1, 300, cycles);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL find_pkt_count: got %0d packets, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL find_pkt%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({found_o, exhausted_o, error_o, busy_o} !== 4'b1000 || nonce_o !== 32'd2) begin
      n_fail++;
      $display("FAIL find_status: f/x/e/b %b nonce %h, required 1000 nonce 2", {found_o, exhausted_o, error_o, busy_o}, nonce_o);
    end
    last_nonce = nonce_o === 32'd2 ? 32'd2 : m_nonce;
  endtask

  task automatic test_guard_window();
    int cyc, npk, null_cyc, first_cyc;
    logic [44:0] p;
    logic [31:0] ns;
    ns = $urandom;
    randomize_vectors();
    barrier_i = 3'b000;
    nonce_start_i = ns;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0; npk = 0; null_cyc = -100; first_cyc = 0;
    while (busy_o && cyc < 400) begin
      p = cur_pkt();
      if (p != HOLD) begin
        npk++;
        if (npk == 14) null_cyc = cyc + 1;
        if (npk == 15) begin
          first_cyc = cyc;
          barrier_i = 3'b010;
          n_checks++;
          if (p !== mk(OP_REG, 1, ns)) begin
            n_fail++;
            $display("FAIL guard_first_nonce: got %h, required %h", p, mk(OP_REG, 1, ns));
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (first_cyc - null_cyc < GUARD + SETTLE + 1 || first_cyc - null_cyc > GUARD + SETTLE + 3) begin
      n_fail++;
      $display("FAIL guard_gap: %0d cycles from closing NULL to LDNONCE, required %0d..%0d",
               first_cyc - null_cyc, GUARD + SETTLE + 1, GUARD + SETTLE + 3);
    end
    n_checks++;
    if (npk != 17 || error_o !== 1'b1 || found_o !== 1'b0 || cyc >= 400) begin
      n_fail++;
      $display("FAIL guard_single_group: %0d pkts err %b found %b cyc %0d, required 17 pkts err 1 found 0",
               npk, error_o, found_o, cyc);
    end
    last_nonce = ns;
  endtask

  task automatic test_exhaust();
    int cycles;
    randomize_vectors();
    resp_list = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    idle_bar = 3'b100;
    model_job(32'hFFFF_FFFE);
    run_job(32'hFFFF_FFFE, -1, 300, cycles);
    n_checks++;
    if (got_q.size() != 20 || got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL exhaust_pkt_count: got %0d packets, required 20", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL exhaust_pkt%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({found_o, exhausted_o, error_o, busy_o} !== 4'b0100 || nonce_o !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL exhaust_status: f/x/e/b %b nonce %h, required 0100 nonce ffffffff", {found_o, exhausted_o, error_o, busy_o}, nonce_o);
    end
    last_nonce = 32'hFFFF_FFFF;
  endtask

  task automatic test_exception_in_wait();
    int cycles, extra;
    randomize_vectors();
    resp_list.delete();
    idle_bar = 3'b010;
    run_job($urandom, 25, 300, cycles);
    n_checks++;
    if (cycles != 26 || error_o !== 1'b1) begin
      n_fail++;
      $display("FAIL exc_wait_latency: ended at cycle %0d err %b, required cycle 26 err 1", cycles, error_o);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (cur_pkt() != HOLD || busy_o || !error_o) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL exc_wait_hold: %0d non-hold cycles after error, required 0", extra);
    end
  endtask

  task automatic test_exception_latched();
    int cycles;
    randomize_vectors();
    resp_list = '{3'b000, 3'b000};
    idle_bar = 3'b010;
    run_job($urandom, 3, 300, cycles);
    n_checks++;
    if (got_q.size() != 14 || error_o !== 1'b1 || nonce_o !== last_nonce || cycles > 17) begin
      n_fail++;
      $display("FAIL exc_latched: %0d pkts err %b nonce %h cyc %0d, required 14 pkts err 1 nonce %h cyc<=17",
               got_q.size(), error_o, nonce_o, cycles, last_nonce);
    end
  endtask

  task automatic test_timeout();
    int cycles;
    randomize_vectors();
    resp_list.delete();
    idle_bar = 3'b010;
    run_job($urandom, -1, 400, cycles);
    n_checks++;
    if (cycles < int'(TMO) + 15 || cycles > int'(TMO) + 18 || error_o !== 1'b1 || got_q.size() != 14) begin
      n_fail++;
      $display("FAIL timeout: ended at cycle %0d err %b pkts %0d, required cycle %0d..%0d err 1 pkts 14",
               cycles, error_o, got_q.size(), int'(TMO) + 15, int'(TMO) + 18);
    end
  endtask

  task automatic test_random_jobs();
    int cycles, nz;
    logic [31:0] ns;
    for (int it = 0; it < 6; it++) begin
      randomize_vectors();
      ns = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
      nz = $urandom_range(0, 4);
      resp_list.delete();
      for (int k = 0; k < nz; k++) resp_list.push_back(3'b000);
      resp_list.push_back(3'b001);
      idle_bar = 3'($urandom_range(2, 7));
      model_job(ns);
      run_job(ns, -1, 400, cycles);
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_pkt_count: got %0d packets, required %0d", it, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_pkt%0d: got %h, required %h", it, i, got_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if ({found_o, exhausted_o, error_o, busy_o} !== {m_found, m_exh, m_err, 1'b0} || nonce_o !== m_nonce) begin
        n_fail++;
        $display("FAIL rand%0d_status: f/x/e/b %b nonce %h, required %b nonce %h", it,
                 {found_o, exhausted_o, error_o, busy_o}, nonce_o, {m_found, m_exh, m_err, 1'b0}, m_nonce);
      end
      last_nonce = m_nonce;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_loadwork();
    test_loadwork();
    test_find_sequence();
    test_guard_window();
    test_exhaust();
    test_exception_in_wait();
    test_exception_latched();
    test_timeout();
    test_random_jobs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
